// File: rtl/backscatter_encoder.sv
// Backscatter baseband encoder: turns the output controller's serial bit stream into
// FM0 or Miller-subcarrier levels on o_mod and paces the controller with o_datarate.
module backscatter_encoder #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_blf_tick,
    input  logic [1:0] i_m,
    input  logic       i_data,
    input  logic       i_enable,
    input  logic       i_mblf,
    input  logic       i_violate,
    output logic       o_datarate,
    output logic       o_mod,
    output logic       o_busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned M_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BIT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [M_W-1:0]     m_q, m_d;
    logic               run_q, run_d;
    logic               phase_q, phase_d;
    logic               sc_q, sc_d;
    logic               prev_q, prev_d;
    logic               data_q, data_d;
    logic               en_q, en_d;
    logic               mblf_q, mblf_d;
    logic               mod_q, mod_d;
    logic               dr_q, dr_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   p_last;
    logic [CNT_W-1:0]   mid_cnt;
    logic               miller;

    // Bit period (last tick index) and Miller mid-bit tick for the latched mode.
    always_comb begin
        p_last  = CNT_W'(1);
        mid_cnt = CNT_W'(0);
        miller  = (m_q != M_W'(0));
        case (m_q)
            2'b01:   begin p_last = CNT_W'(3);  mid_cnt = CNT_W'(2); end
            2'b10:   begin p_last = CNT_W'(7);  mid_cnt = CNT_W'(4); end
            2'b11:   begin p_last = CNT_W'(15); mid_cnt = CNT_W'(8); end
            default: begin p_last = CNT_W'(1);  mid_cnt = CNT_W'(0); end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        run_d   = i_run;
        phase_d = phase_q;
        sc_d    = sc_q;
        prev_d  = prev_q;
        data_d  = data_q;
        en_d    = en_q;
        mblf_d  = mblf_q;
        dr_d    = 1'b0;

        if (!i_run) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            m_d     = i_m;
            phase_d = 1'b0;
            sc_d    = 1'b0;
            prev_d  = 1'b1;
            data_d  = 1'b0;
            en_d    = 1'b0;
            mblf_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    m_d = i_m;
                    if (!run_q) state_d = S_WAIT;
                end
                // Entering BIT parks the counter on the last tick so the next tick
                // opens bit 0 after the controller has had time to present it.
                S_WAIT: begin
                    if (i_blf_tick) begin
                        state_d = S_BIT;
                        cnt_d   = p_last;
                        sc_d    = 1'b0;
                        dr_d    = 1'b1;
                    end
                end
                S_BIT: begin
                    if (i_blf_tick) begin
                        cnt_d = (cnt_q == p_last) ? '0 : CNT_W'(cnt_q + CNT_W'(1));
                        if (cnt_d == p_last) dr_d = 1'b1;
                        if (cnt_d == '0) begin
                            if (en_q && !(miller && mblf_q)) prev_d = data_q;
                            data_d = i_data;
                            en_d   = i_enable;
                            mblf_d = i_mblf;
                            sc_d   = 1'b0;
                            if (!miller) begin
                                if (!i_violate) phase_d = ~phase_q;
                            end else if (!i_mblf && !i_data && !prev_d) begin
                                phase_d = ~phase_q;
                            end
                        end else begin
                            sc_d = ~sc_q;
                            if (!miller) begin
                                if (cnt_d == CNT_W'(1) && !data_q) phase_d = ~phase_q;
                            end else if (!mblf_q && cnt_d == mid_cnt && data_q) begin
                                phase_d = ~phase_q;
                            end
                        end
                    end
                    if (!en_d) phase_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_BIT);
        if (state_d != S_BIT || !en_d) begin
            mod_d = IDLE_LEVEL;
        end else if (!miller) begin
            mod_d = phase_d;
        end else if (mblf_d) begin
            mod_d = sc_d;
        end else begin
            mod_d = phase_d ^ sc_d;
        end
    end

    // run_q resets high so a held i_run is not mistaken for a fresh start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            run_q   <= 1'b1;
            phase_q <= 1'b0;
            sc_q    <= 1'b0;
            prev_q  <= 1'b1;
            data_q  <= 1'b0;
            en_q    <= 1'b0;
            mblf_q  <= 1'b0;
            mod_q   <= IDLE_LEVEL;
            dr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            run_q   <= run_d;
            phase_q <= phase_d;
            sc_q    <= sc_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            en_q    <= en_d;
            mblf_q  <= mblf_d;
            mod_q   <= mod_d;
            dr_q    <= dr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_mod      = mod_q;
    assign o_datarate = dr_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_backscatter_encoder.sv
// Directed bench for backscatter_encoder with a tiny output-controller model that
// presents the next bit one clk after each o_datarate strobe.
module tb_backscatter_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_run;
    logic       i_blf_tick;
    logic [1:0] i_m;
    logic       i_data;
    logic       i_enable;
    logic       i_mblf;
    logic       i_violate;
    logic       o_datarate;
    logic       o_mod;
    logic       o_busy;

    backscatter_encoder #(.IDLE_LEVEL(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (i_run),
        .i_blf_tick (i_blf_tick),
        .i_m        (i_m),
        .i_data     (i_data),
        .i_enable   (i_enable),
        .i_mblf     (i_mblf),
        .i_violate  (i_violate),
        .o_datarate (o_datarate),
        .o_mod      (o_mod),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stray = 0;

    logic [31:0] c_data, c_mblf, c_viol;
    int          c_len, c_idx;
    logic [31:0] mods, strb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ctrl_load(input logic [31:0] d, input logic [31:0] p,
                             input logic [31:0] v, input int len);
        c_data = d; c_mblf = p; c_viol = v; c_len = len; c_idx = 0;
        i_data = 1'b0; i_enable = 1'b0; i_mblf = 1'b0; i_violate = 1'b0;
    endtask

    task automatic ctrl_advance();
        if (c_idx < c_len) begin
            i_data    = c_data[c_idx];
            i_mblf    = c_mblf[c_idx];
            i_violate = c_viol[c_idx];
            i_enable  = 1'b1;
            c_idx++;
        end else begin
            i_data = 1'b0; i_mblf = 1'b0; i_violate = 1'b0; i_enable = 1'b0;
        end
    endtask

    // One tick every 4 clk; o_mod / o_datarate sampled on the negedge after the tick edge.
    task automatic do_tick(output logic m, output logic d);
        @(negedge clk) i_blf_tick = 1'b1;
        @(negedge clk) i_blf_tick = 1'b0;
        m = o_mod;
        d = o_datarate;
        if (d) ctrl_advance();
        repeat (2) begin
            @(negedge clk);
            if (o_datarate) stray++;
        end
    endtask

    task automatic run_ticks(input int n, output logic [31:0] mv, output logic [31:0] sv);
        logic m, d;
        mv = '0;
        sv = '0;
        for (int i = 0; i < n; i++) begin
            do_tick(m, d);
            mv = {mv[30:0], m};
            sv = {sv[30:0], d};
        end
    endtask

    task automatic start_frame(input logic [1:0] m);
        @(negedge clk);
        i_run = 1'b0;
        i_m   = m;
        stray = 0;
        repeat (2) @(negedge clk);
        i_run = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; i_run = 1'b0; i_blf_tick = 1'b0; i_m = 2'b00;
        ctrl_load('0, '0, '0, 0);
        repeat (3) @(negedge clk);
        check("rst_mod", 32'(o_mod), 32'(0));
        check("rst_datarate", 32'(o_datarate), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // FM0 data 1,0,1,1
        ctrl_load(32'b1101, '0, '0, 4);
        start_frame(2'b00);
        check("fm0_wait_busy", 32'(o_busy), 32'(0));
        run_ticks(10, mods, strb);
        check("fm0_mod", mods, 32'(10'b0_11_01_00_11_0));
        check("fm0_strobe", strb, 32'(10'b1_01_01_01_01_0));
        check("fm0_stray", 32'(stray), 32'(0));

        // FM0 preamble 1,0,1,0,v,1 with violation on bit 5
        ctrl_load(32'b110101, '0, 32'b010000, 6);
        start_frame(2'b00);
        run_ticks(14, mods, strb);
        check("fm0v_mod", mods, 32'(14'b0_11_01_00_10_00_11_0));
        check("fm0v_strobe", strb, 32'(14'b1_01_01_01_01_01_01_0));

        // Miller M4 data 0,0,1
        ctrl_load(32'b100, '0, '0, 3);
        start_frame(2'b10);
        run_ticks(26, mods, strb);
        check("m4_mod", mods, 32'(26'b0_01010101_10101010_10100101_0));
        check("m4_strobe", strb, 32'(26'b1_00000001_00000001_00000001_0));
        check("m4_stray", 32'(stray), 32'(0));

        // Miller M2: 4 pilot bits then data 0,0
        ctrl_load(32'b000000, 32'b001111, '0, 6);
        start_frame(2'b01);
        run_ticks(26, mods, strb);
        check("m2p_mod", mods, 32'(26'b0_0101_0101_0101_0101_0101_1010_0));
        check("m2p_strobe", strb, 32'(26'b1_0001_0001_0001_0001_0001_0001_0));

        // M8 abort at tick_cnt 3, with a tick landing on the i_run fall
        ctrl_load(32'hFFFF_FFFF, '0, '0, 20);
        start_frame(2'b11);
        run_ticks(5, mods, strb);
        check("m8_busy", 32'(o_busy), 32'(1));
        check("m8_mod_pre", 32'(mods[0]), 32'(1));
        @(negedge clk);
        i_run = 1'b0;
        i_blf_tick = 1'b1;
        @(negedge clk);
        i_blf_tick = 1'b0;
        check("abort_mod", 32'(o_mod), 32'(0));
        check("abort_busy", 32'(o_busy), 32'(0));
        check("abort_strobe", 32'(o_datarate), 32'(0));
        run_ticks(3, mods, strb);
        check("abort_idle_strobe", strb, 32'(0));

        // Restart in M2; i_m change mid-run must be ignored
        ctrl_load(32'hFFFF_FFFF, '0, '0, 20);
        start_frame(2'b01);
        i_m = 2'b11;
        run_ticks(9, mods, strb);
        check("m2_restart_strobe", strb, 32'(9'b1_0001_0001));
        check("m2_restart_stray", 32'(stray), 32'(0));

        // Async reset mid-frame with i_run held high
        ctrl_load(32'hFFFF_FFFF, '0, '0, 20);
        start_frame(2'b00);
        run_ticks(2, mods, strb);
        check("pre_rst_mod", mods, 32'(2'b01));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mod", 32'(o_mod), 32'(0));
        check("arst_busy", 32'(o_busy), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        run_ticks(4, mods, strb);
        check("held_run_strobe", strb, 32'(0));
        check("held_run_busy", 32'(o_busy), 32'(0));
        ctrl_load(32'hFFFF_FFFF, '0, '0, 20);
        start_frame(2'b00);
        run_ticks(3, mods, strb);
        check("rerun_strobe", strb, 32'(3'b101));
        check("rerun_busy", 32'(o_busy), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
